// File: rtl/aes_pkg.sv
// Shared types and sizes for the AES host-side pin driver.
// AES_HOST_TIMEOUT_EN enables the WAIT-state timeout in aes_host_driver.
package aes_pkg;

    localparam int unsigned AES_DATA_W     = 128;
    localparam int unsigned AES_NIB_W      = 4;
    localparam int unsigned AES_RES_W      = 8;
    localparam int unsigned NIBBLES        = AES_DATA_W / AES_NIB_W;
    localparam int unsigned BYTES          = AES_DATA_W / AES_RES_W;
    localparam int unsigned CNT_W          = 5;
    localparam int unsigned TIMEOUT_CYCLES = 4096;
    localparam int unsigned TMO_W          = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT,
        ST_CAPTURE,
        ST_RESP
    } aes_state_e;

endpackage

// File: rtl/aes_host_shreg.sv
// Load/shift-out register: parallel load, then shifts left, top SHIFT_W bits exposed.
// Zero fill means the output reads 0 once the whole word has been shifted out.
module aes_host_shreg #(
    parameter int unsigned WIDTH   = 128,
    parameter int unsigned SHIFT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               shift,
    input  logic [WIDTH-1:0]   load_data,
    output logic [SHIFT_W-1:0] top
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (load) begin
            data_d = load_data;
        end else if (shift) begin
            data_d = {data_q[WIDTH-SHIFT_W-1:0], SHIFT_W'(0)};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign top = data_q[WIDTH-1 -: SHIFT_W];

endmodule

// File: rtl/aes_host_driver.sv
// Host-side driver for the AES chip pin interface: serialises block/key, collects result bytes.
// Define AES_HOST_TIMEOUT_EN to bound the wait for the first done.
module aes_host_driver
    import aes_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [AES_DATA_W-1:0] block_data,
    input  logic [AES_DATA_W-1:0] key_data,
    input  logic                  test_mode,
    output logic                  aes_en,
    output logic                  aes_test,
    output logic [AES_NIB_W-1:0]  aes_block,
    output logic [AES_NIB_W-1:0]  aes_key,
    input  logic [AES_RES_W-1:0]  aes_result,
    input  logic                  aes_done,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [AES_DATA_W-1:0] result_data,
    output logic                  rsp_err
);

    aes_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  en_q, en_d;
    logic                  test_q, test_d;
    logic                  req_ready_q, req_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [AES_DATA_W-1:0] result_q, result_d;
    logic [3:0]            byte_idx;
    logic                  accept;
    logic                  shifting;
`ifdef AES_HOST_TIMEOUT_EN
    logic [TMO_W-1:0]      tmo_q, tmo_d;
`endif

    assign accept   = (state_q == ST_IDLE) && req_valid && req_ready_q;
    assign shifting = (state_q == ST_LOAD);

    aes_host_shreg #(.WIDTH(AES_DATA_W), .SHIFT_W(AES_NIB_W)) u_block_shreg (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .shift     (shifting),
        .load_data (block_data),
        .top       (aes_block)
    );

    aes_host_shreg #(.WIDTH(AES_DATA_W), .SHIFT_W(AES_NIB_W)) u_key_shreg (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .shift     (shifting),
        .load_data (key_data),
        .top       (aes_key)
    );

    // Next-state and registered-output logic; result bytes land MSB-first by counter.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        en_d        = en_q;
        test_d      = test_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        result_d    = result_q;
        byte_idx    = 4'(BYTES - 1) - cnt_q[3:0];
`ifdef AES_HOST_TIMEOUT_EN
        tmo_d       = tmo_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    req_ready_d = 1'b0;
                    en_d        = 1'b1;
                    test_d      = test_mode;
                    cnt_d       = '0;
                    result_d    = '0;
                    rsp_err_d   = 1'b0;
                    state_d     = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (cnt_q == CNT_W'(NIBBLES - 1)) begin
                    en_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_WAIT;
`ifdef AES_HOST_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT: begin
                if (aes_done) begin
                    result_d[AES_DATA_W-1 -: AES_RES_W] = aes_result;
                    cnt_d   = CNT_W'(1);
                    state_d = ST_CAPTURE;
                end
`ifdef AES_HOST_TIMEOUT_EN
                else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    result_d    = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
`endif
            end
            ST_CAPTURE: begin
                if (aes_done) begin
                    result_d[{byte_idx, 3'b000} +: AES_RES_W] = aes_result;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == CNT_W'(BYTES)) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b0;
                        state_d     = ST_RESP;
                    end
                end else begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    test_d      = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            en_q        <= 1'b0;
            test_q      <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            result_q    <= '0;
`ifdef AES_HOST_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            en_q        <= en_d;
            test_q      <= test_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            result_q    <= result_d;
`ifdef AES_HOST_TIMEOUT_EN
            tmo_q       <= tmo_d;
`endif
        end
    end

    assign req_ready   = req_ready_q;
    assign aes_en      = en_q;
    assign aes_test    = test_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_err     = rsp_err_q;
    assign result_data = result_q;

endmodule

// File: tb/tb_aes_host_driver.sv
// Self-checking bench for aes_host_driver with a behavioural chip/host model.
// Honours AES_HOST_TIMEOUT_EN when checking the no-done case.
`timescale 1ns/1ps
module tb_aes_host_driver;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [127:0] block_data;
    logic [127:0] key_data;
    logic         test_mode;
    logic         aes_en;
    logic         aes_test;
    logic [3:0]   aes_block;
    logic [3:0]   aes_key;
    logic [7:0]   aes_result;
    logic         aes_done;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [127:0] result_data;
    logic         rsp_err;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    aes_host_driver dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .block_data  (block_data),
        .key_data    (key_data),
        .test_mode   (test_mode),
        .aes_en      (aes_en),
        .aes_test    (aes_test),
        .aes_block   (aes_block),
        .aes_key     (aes_key),
        .aes_result  (aes_result),
        .aes_done    (aes_done),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .result_data (result_data),
        .rsp_err     (rsp_err)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %032h expected %032h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // i-th nibble on the wire, first transmitted is the most significant
    function automatic logic [3:0] wire_nib(input logic [127:0] v, input int i);
        logic [127:0] t;
        t = v >> (4 * (31 - i));
        return t[3:0];
    endfunction

    function automatic logic [7:0] chip_byte(input logic [127:0] ct, input int j);
        logic [127:0] t;
        t = ct >> (8 * (15 - j));
        return t[7:0];
    endfunction

    // Expected ciphertext when only the first n bytes arrived
    function automatic logic [127:0] exp_result(input logic [127:0] ct, input int n);
        logic [127:0] ones;
        ones = '1;
        if (n >= 16) return ct;
        return ct & ~(ones >> (8 * n));
    endfunction

    // One full operation; entered and left on a negedge.
    task automatic run_op(input logic [127:0] blk, input logic [127:0] key, input logic tm,
                          input logic [127:0] ct, input int ndone, input int wdly,
                          input int rdly, input bit hold_req, input bit noise);
        int lat;
        logic [127:0] exp_r;
        bit exp_e;
        exp_r = exp_result(ct, ndone);
        exp_e = (ndone < 16);
        req_valid  = 1'b1;
        block_data = blk;
        key_data   = key;
        test_mode  = tm;
        check("req_ready_idle", 128'(req_ready), 128'(1));
        @(negedge clk);
        req_valid = 1'b0;
        test_mode = 1'b0;
        for (int i = 0; i < 32; i++) begin
            aes_done   = noise ? 1'($urandom % 2) : 1'b0;
            aes_result = 8'($urandom);
            check("load_en", 128'(aes_en), 128'(1));
            check("load_block", 128'(aes_block), 128'(wire_nib(blk, i)));
            check("load_key", 128'(aes_key), 128'(wire_nib(key, i)));
            check("load_test", 128'(aes_test), 128'(tm));
            check("load_req_ready", 128'(req_ready), 128'(0));
            @(negedge clk);
        end
        aes_done = 1'b0;
        check("wait_en", 128'(aes_en), 128'(0));
        check("wait_pins", 128'({aes_block, aes_key}), 128'(0));
        for (int w = 0; w < wdly; w++) begin
            check("wait_test", 128'(aes_test), 128'(tm));
            check("wait_no_rsp", 128'(rsp_valid), 128'(0));
            @(negedge clk);
        end
        for (int j = 0; j < ndone; j++) begin
            aes_done   = 1'b1;
            aes_result = chip_byte(ct, j);
            @(negedge clk);
        end
        aes_done = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        check("rsp_latency", 128'(lat), 128'(exp_e ? 1 : 0));
        for (int r = 0; r < rdly; r++) begin
            req_valid = hold_req;
            aes_done  = noise ? 1'($urandom % 2) : 1'b0;
            aes_result = 8'($urandom);
            check("rsp_hold_valid", 128'(rsp_valid), 128'(1));
            check("rsp_hold_data", result_data, exp_r);
            check("rsp_hold_err", 128'(rsp_err), 128'(exp_e));
            check("rsp_req_ready", 128'(req_ready), 128'(0));
            check("rsp_no_accept", 128'(aes_en), 128'(0));
            check("rsp_test", 128'(aes_test), 128'(tm));
            @(negedge clk);
        end
        check("rsp_data", result_data, exp_r);
        check("rsp_err", 128'(rsp_err), 128'(exp_e));
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        aes_done  = 1'b0;
        check("post_rsp_valid", 128'(rsp_valid), 128'(0));
        check("post_req_ready", 128'(req_ready), 128'(1));
        check("post_test", 128'(aes_test), 128'(0));
        check("post_en", 128'(aes_en), 128'(0));
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] ct;
        int           nd;
        int           c;
        bit           seen;
        rst        = 1'b1;
        req_valid  = 1'b0;
        block_data = '0;
        key_data   = '0;
        test_mode  = 1'b0;
        aes_result = '0;
        aes_done   = 1'b0;
        rsp_ready  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_req_ready", 128'(req_ready), 128'(1));
        check("rst_en", 128'(aes_en), 128'(0));
        check("rst_test", 128'(aes_test), 128'(0));
        check("rst_pins", 128'({aes_block, aes_key}), 128'(0));
        check("rst_rsp_valid", 128'(rsp_valid), 128'(0));
        check("rst_rsp_err", 128'(rsp_err), 128'(0));
        check("rst_result", result_data, 128'(0));

        // FIPS-197 appendix C.1 transport
        run_op(128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f, 1'b0,
               128'h69c4e0d86a7b0430d8cdb78070b4c55a, 16, 3, 0, 1'b0, 1'b0);
        check("fips_result", result_data, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);

        // Backpressure with a pending request and test_mode set
        run_op(rand128(), rand128(), 1'b1, rand128(), 16, 0, 20, 1'b1, 1'b1);

        // Short done stream of five bytes
        run_op(rand128(), rand128(), 1'b0, rand128(), 5, 2, 2, 1'b0, 1'b1);
        check("short_tail", {40'h0, result_data[87:0]}, 128'(0));

        // Reset on LOAD cycle 10
        req_valid  = 1'b1;
        block_data = rand128();
        key_data   = rand128();
        test_mode  = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        test_mode = 1'b0;
        repeat (10) @(negedge clk);
        check("abort_pre_en", 128'(aes_en), 128'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_en", 128'(aes_en), 128'(0));
        check("abort_req_ready", 128'(req_ready), 128'(1));
        check("abort_test", 128'(aes_test), 128'(0));
        check("abort_pins", 128'({aes_block, aes_key}), 128'(0));
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            aes_done   = 1'b1;
            aes_result = 8'($urandom);
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        aes_done = 1'b0;
        check("abort_no_rsp", 128'(seen), 128'(0));
        run_op(rand128(), rand128(), 1'b0, rand128(), 16, 1, 1, 1'b0, 1'b0);

        // Randomised operations
        for (int t = 0; t < 12; t++) begin
            nd = ($urandom % 2 == 0) ? 16 : int'($urandom_range(1, 16));
            run_op(rand128(), rand128(), 1'($urandom % 2), rand128(), nd,
                   int'($urandom_range(0, 6)), int'($urandom_range(0, 4)),
                   1'($urandom % 2), 1'b1);
        end

        // Chip never signals done
        ct = '0;
        req_valid  = 1'b1;
        block_data = rand128();
        key_data   = rand128();
        @(negedge clk);
        req_valid = 1'b0;
        repeat (32) @(negedge clk);
        check("nodone_wait_en", 128'(aes_en), 128'(0));
`ifdef AES_HOST_TIMEOUT_EN
        c = 0;
        while (!rsp_valid && c < 5000) begin
            @(negedge clk);
            c++;
        end
        check("timeout_cycles", 128'(c), 128'(4096));
        check("timeout_err", 128'(rsp_err), 128'(1));
        check("timeout_result", result_data, ct);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("timeout_post_ready", 128'(req_ready), 128'(1));
`else
        c = 0;
        seen = 1'b0;
        repeat (10000) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
            c++;
        end
        check("no_timeout_rsp", 128'(seen), 128'(0));
        check("no_timeout_ready", 128'(req_ready), 128'(0));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("no_timeout_rst_ready", 128'(req_ready), 128'(1));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
